spi_slave_sync: RTL and testbench
=================================

// Module: spi_slave_sync
// PURPOSE
//  SPI responder clocked by the system clock CLK, the far end of the SPI Master. SCLK, SS_N
//  and MOSI are treated as asynchronous pins, then synchronised and edge-detected.
//  It supports all four CPOL/CPHA combinations and moves full-duplex words, MSB first.
//  It has a one-deep TX holding register (ready/load handshake) and an RX valid pulse.
//  It sits between the SPI pins and a local register file or controller.
// PARAMETERS
//  DATA_W      8      word length in bits (>=2)
//  DEFAULT_TX  8'h00  word shifted out when the holding register is empty at word start
// PORTS
//  CLK          in   1       system clock, rising edge
//  RST          in   1       synchronous reset, active-high
//  CPOL_IN      in   1       SCLK idle level
//  CPHA_IN      in   1       0: sample on leading edge; 1: sample on trailing edge
//  SCLK         in   1       SPI clock from master (async)
//  SS_N         in   1       slave select, active-low (async)
//  MOSI         in   1       master-out data (async)
//  MISO         out  1       slave-out data
//  MISO_OE      out  1       MISO output enable (tri-state control at top level)
//  TX_DATA      in   DATA_W  word to send next
//  TX_LOAD      in   1       write TX_DATA into holding reg; honoured only when TX_READY=1
//  TX_READY     out  1       holding register empty
//  RX_DATA      out  DATA_W  last complete received word
//  RX_VALID     out  1       1-cycle pulse: RX_DATA updated
//  TX_UNDERRUN  out  1       1-cycle pulse: DEFAULT_TX was loaded because holding reg was empty
//  FRAME_ABORT  out  1       1-cycle pulse: SS_N deasserted with a partial word (1..DATA_W-1 bits)
// BEHAVIOUR
//  - Reset: MISO=0, MISO_OE=0, TX_READY=1, RX_DATA=0, all pulses 0.
//    Bit counter 0, holding reg empty, state WAIT_IDLE.
//  - Sync: SCLK, SS_N and MOSI each pass through 2 flops. Edges are taken from the synced
//    SCLK versus its previous value. Pin-to-action latency is 3 CLK.
//  - SCLK high and low phases must each last at least 4 CLK. Faster SCLK is unsupported.
//  - Leading edge = SCLK leaving CPOL_IN level; trailing edge = returning to it.
//    Sample edge = leading if CPHA=0, else trailing; shift edge = the other.
//  - CPOL_IN/CPHA_IN are latched when SS_N falls and are ignored for the rest of the frame.
//  - FSM:
//    WAIT_IDLE: -> IDLE once synced SS_N=1. This keeps a mid-frame reset from joining a frame late.
//    IDLE: MISO_OE=0. On synced SS_N fall -> LOAD.
//    LOAD (1 cycle): shift reg <= holding reg (TX_READY->1) or DEFAULT_TX with TX_UNDERRUN pulse.
//      Set bit counter=0 and MISO_OE=1. If CPHA=0, MISO=MSB now. -> SHIFT.
//    SHIFT: on sample edge, rx_shift <= {rx_shift, MOSI} and count++.
//      On shift edge, present next bit on MISO, except the first leading edge when CPHA=0.
//      If CPHA=1, MISO is first driven (MSB) on the first leading edge.
//      At count==DATA_W after a sample edge: RX_DATA <= rx_shift and RX_VALID pulses.
//      Then reload exactly as in LOAD, in the same cycle, so back-to-back words need no gap.
//      Synced SS_N rise -> IDLE. FRAME_ABORT pulses if 0<count<DATA_W. A partial word is dropped.
//  - TX_LOAD while TX_READY=0 is ignored, and the holding reg is kept.
//    TX_LOAD in the same cycle as a reload:
//    the reload takes the old holding content, or DEFAULT_TX if empty; the new word lands in holding.
//  - RX_DATA holds until the next complete word. It is not cleared by SS_N.
//  - Reset mid-frame: all outputs go to reset values next cycle.
//    No RX_VALID or FRAME_ABORT fires for the interrupted word.
// TESTING
//  1 Mode0, TX_LOAD 8'hA5, master sends 8'h3C -> master gets A5; RX_DATA=3C; one RX_VALID; no underrun.
//  2 Mode3 (CPOL=1,CPHA=1), load 8'h93, master sends 8'h4E -> master gets 93; RX_DATA=4E.
//  3 Mode1, nothing loaded, DEFAULT_TX=8'h00, master sends 8'hFF
//    -> TX_UNDERRUN at LOAD; master gets 00; RX_DATA=FF.
//  4 Mode2, two words without SS_N gap (load 8'h11, then 8'h22 after TX_READY)
//    -> master gets 11,22; two RX_VALID pulses.
//  5 Mode0, SS_N rises after 5 bits -> FRAME_ABORT pulse; no RX_VALID; RX_DATA unchanged; MISO_OE=0.
//  6 RST=1 for 1 cycle mid-word with SS_N still low -> outputs at reset values.
//    The rest of that frame is ignored; the next full frame (SS_N high then low) transfers correctly.

Source files
------------

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: CLK-domain SPI responder with synchronised pins, all CPOL/CPHA modes, one-deep TX holding register
module spi_slave_sync #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] DEFAULT_TX = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CPOL_IN,
  input  logic              CPHA_IN,
  input  logic              SCLK,
  input  logic              SS_N,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_LOAD,
  output logic              TX_READY,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              TX_UNDERRUN,
  output logic              FRAME_ABORT
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, LOAD, SHIFT} state_t;
  state_t            state_q, state_d;
  logic [2:0]        sclk_q;
  logic [1:0]        ss_q, mosi_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, hold_q, hold_d, rx_data_q, rx_data_d, rx_next;
  logic              full_q, full_d, miso_q, miso_d, oe_q, oe_d, rxv_q, rxv_d;
  logic              und_q, und_d, abort_q, abort_d, cpol_q, cpol_d, cpha_q, cpha_d;
  logic              ss, lead, trail, sample_e, shift_e, reload;
  assign ss          = ss_q[1];
  assign lead        = sclk_q[2] == cpol_q && sclk_q[1] != cpol_q;
  assign trail       = sclk_q[2] != cpol_q && sclk_q[1] == cpol_q;
  assign sample_e    = cpha_q ? trail : lead;
  assign shift_e     = cpha_q ? lead : trail;
  assign rx_next     = {rx_q[DATA_W-2:0], mosi_q[1]};
  assign MISO        = miso_q;
  assign MISO_OE     = oe_q;
  assign TX_READY    = !full_q;
  assign RX_DATA     = rx_data_q;
  assign RX_VALID    = rxv_q;
  assign TX_UNDERRUN = und_q;
  assign FRAME_ABORT = abort_q;
  // next-state: frame FSM, shift registers, holding register and pulses
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    hold_d    = hold_q;
    full_d    = full_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    rx_data_d = rx_data_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    rxv_d     = 1'b0;
    und_d     = 1'b0;
    abort_d   = 1'b0;
    reload    = 1'b0;
    if (TX_LOAD && !full_q) begin
      hold_d = TX_DATA;
      full_d = 1'b1;
    end
    case (state_q)
      WAIT_IDLE: state_d = ss ? IDLE : WAIT_IDLE;
      IDLE: if (!ss) begin
        state_d = LOAD;
        cpol_d  = CPOL_IN;
        cpha_d  = CPHA_IN;
      end
      LOAD: begin
        state_d = SHIFT;
        reload  = 1'b1;
      end
      SHIFT: if (ss) begin
        state_d = IDLE;
        oe_d    = 1'b0;
        miso_d  = 1'b0;
        abort_d = cnt_q != '0;
      end else begin
        if (shift_e) begin
          tx_d   = cnt_q == '0 ? tx_q : {tx_q[DATA_W-2:0], 1'b0};
          miso_d = cnt_q == '0 ? tx_q[DATA_W-1] : tx_q[DATA_W-2];
        end
        if (sample_e) begin
          rx_d  = rx_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) begin
            rx_data_d = rx_next;
            rxv_d     = 1'b1;
            reload    = 1'b1;
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
    if (reload) begin
      tx_d   = full_q ? hold_q : DEFAULT_TX;
      und_d  = !full_q;
      full_d = full_q ? 1'b0 : full_d;
      cnt_d  = '0;
      oe_d   = 1'b1;
      miso_d = cpha_q ? miso_d : tx_d[DATA_W-1];
    end
  end
  // state registers and pin synchronisers; ss chain resets low so a reset mid-frame waits for SS_N high
  always_ff @(posedge CLK) begin
    sclk_q <= {sclk_q[1:0], SCLK};
    mosi_q <= {mosi_q[0], MOSI};
    if (RST) begin
      ss_q      <= '0;
      state_q   <= WAIT_IDLE;
      cnt_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      hold_q    <= '0;
      full_q    <= 1'b0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      rx_data_q <= '0;
      rxv_q     <= 1'b0;
      und_q     <= 1'b0;
      abort_q   <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
    end else begin
      ss_q      <= {ss_q[0], SS_N};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      hold_q    <= hold_d;
      full_q    <= full_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      rx_data_q <= rx_data_d;
      rxv_q     <= rxv_d;
      und_q     <= und_d;
      abort_q   <= abort_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
    end
  end
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed SPI master model with RX scoreboard for spi_slave_sync
`timescale 1ns/1ps
module tb_spi_slave_sync;
  localparam int H = 8;
  logic clk = 1'b0, rst = 1'b1, cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic miso, miso_oe, tx_load = 1'b0, tx_ready, rx_valid, tx_underrun, frame_abort;
  logic [7:0] tx_data = '0, rx_data, mi, mi2;
  logic [7:0] exp_q[$];
  int checks = 0, errors = 0, rxv_cnt = 0, und_cnt = 0, ab_cnt = 0;
  int rxv0, und0, ab0;
  always #5 clk = ~clk;
  spi_slave_sync dut (
    .CLK(clk), .RST(rst), .CPOL_IN(cpol), .CPHA_IN(cpha), .SCLK(sclk), .SS_N(ss_n), .MOSI(mosi),
    .MISO(miso), .MISO_OE(miso_oe), .TX_DATA(tx_data), .TX_LOAD(tx_load), .TX_READY(tx_ready),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .TX_UNDERRUN(tx_underrun), .FRAME_ABORT(frame_abort)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // monitor: pops the scoreboard on every RX_VALID and counts pulses
  always @(negedge clk) if (!rst) begin
    if (rx_valid) begin
      rxv_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %0h expected no word", rx_data);
      end else chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    end
    if (tx_underrun) und_cnt++;
    if (frame_abort) ab_cnt++;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic snap();
    rxv0 = rxv_cnt;
    und0 = und_cnt;
    ab0  = ab_cnt;
  endtask
  task automatic load(input logic [7:0] w);
    int n = 0;
    while (!tx_ready && n < 100) begin
      wait_clk(1);
      n++;
    end
    chk("tx_ready_wait", {31'd0, tx_ready}, 1);
    tx_data = w;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
  endtask
  task automatic begin_frame(input logic p, input logic a);
    cpol = p;
    cpha = a;
    sclk = p;
    wait_clk(H);
    ss_n = 1'b0;
    wait_clk(H);
  endtask
  task automatic end_frame();
    wait_clk(H);
    ss_n = 1'b1;
    wait_clk(2 * H);
  endtask
  task automatic word(input logic [7:0] mo, input int n, output logic [7:0] got);
    got = '0;
    for (int b = 0; b < n; b++) begin
      if (!cpha) begin
        mosi = mo[7-b];
        wait_clk(H);
        got[7-b] = miso;
        sclk = ~cpol;
        wait_clk(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[7-b];
        wait_clk(H);
        got[7-b] = miso;
        sclk = cpol;
        wait_clk(H);
      end
    end
  endtask
  initial begin
    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    chk("reset_miso", {31'd0, miso}, 0);
    chk("reset_oe", {31'd0, miso_oe}, 0);
    chk("reset_ready", {31'd0, tx_ready}, 1);
    chk("reset_rx_data", {24'd0, rx_data}, 0);
    chk("reset_pulses", {29'd0, rx_valid, tx_underrun, frame_abort}, 0);
    wait_clk(2 * H);
    // mode 0
    load(8'hA5);
    snap();
    begin_frame(1'b0, 1'b0);
    chk("t1_no_underrun_at_load", und_cnt - und0, 0);
    chk("t1_oe_in_frame", {31'd0, miso_oe}, 1);
    exp_q.push_back(8'h3C);
    word(8'h3C, 8, mi);
    end_frame();
    chk("t1_master_rx", {24'd0, mi}, 32'hA5);
    chk("t1_rx_valid_count", rxv_cnt - rxv0, 1);
    chk("t1_ready_after", {31'd0, tx_ready}, 1);
    // mode 3
    load(8'h93);
    snap();
    begin_frame(1'b1, 1'b1);
    exp_q.push_back(8'h4E);
    word(8'h4E, 8, mi);
    end_frame();
    chk("t2_master_rx", {24'd0, mi}, 32'h93);
    chk("t2_rx_data", {24'd0, rx_data}, 32'h4E);
    chk("t2_no_abort", ab_cnt - ab0, 0);
    // mode 1, empty holding register
    snap();
    begin_frame(1'b0, 1'b1);
    chk("t3_underrun_at_load", und_cnt - und0, 1);
    exp_q.push_back(8'hFF);
    word(8'hFF, 8, mi);
    end_frame();
    chk("t3_master_rx", {24'd0, mi}, 32'h00);
    chk("t3_rx_data", {24'd0, rx_data}, 32'hFF);
    // mode 2, two back-to-back words
    load(8'h11);
    snap();
    begin_frame(1'b1, 1'b0);
    load(8'h22);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    word(8'h44, 8, mi);
    chk("t4_no_underrun_word1", und_cnt - und0, 0);
    word(8'h55, 8, mi2);
    end_frame();
    chk("t4_master_rx0", {24'd0, mi}, 32'h11);
    chk("t4_master_rx1", {24'd0, mi2}, 32'h22);
    chk("t4_rx_valid_count", rxv_cnt - rxv0, 2);
    // mode 0, partial word
    snap();
    begin_frame(1'b0, 1'b0);
    word(8'hE7, 5, mi);
    end_frame();
    chk("t5_abort", ab_cnt - ab0, 1);
    chk("t5_no_rx_valid", rxv_cnt - rxv0, 0);
    chk("t5_rx_data_kept", {24'd0, rx_data}, 32'h55);
    chk("t5_oe_off", {31'd0, miso_oe}, 0);
    // reset in the middle of a word
    load(8'h5A);
    begin_frame(1'b0, 1'b0);
    word(8'hC0, 3, mi);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    snap();
    chk("t6_rst_miso", {31'd0, miso}, 0);
    chk("t6_rst_oe", {31'd0, miso_oe}, 0);
    chk("t6_rst_ready", {31'd0, tx_ready}, 1);
    chk("t6_rst_rx_data", {24'd0, rx_data}, 0);
    word(8'h1F, 5, mi);
    chk("t6_oe_stays_off", {31'd0, miso_oe}, 0);
    end_frame();
    chk("t6_ignored_frame", (rxv_cnt - rxv0) + (ab_cnt - ab0) + (und_cnt - und0), 0);
    load(8'hC3);
    begin_frame(1'b0, 1'b0);
    exp_q.push_back(8'h96);
    word(8'h96, 8, mi);
    end_frame();
    chk("t6_master_rx", {24'd0, mi}, 32'hC3);
    chk("t6_rx_data", {24'd0, rx_data}, 32'h96);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
